// File: rtl/io_uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : io_uart_baud_gen
//  Description : 16x-baud clock generator for the console UART XTR input.
//                The panel switch is synchronised and debounced, and a new
//                rate is applied only at a period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart_baud_gen #(
    parameter int unsigned CLK_HZ        = 39_321_600,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter logic [3:0]  RESET_SEL     = 4'd14
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       ENABLE,
    input  logic [3:0] BAUD_RATE_SWITCH,
    output logic       XTR,
    output logic       XTR_TICK,
    output logic [3:0] BAUD_SEL,
    output logic       RATE_CHG
);

    localparam int unsigned          STAB_W   = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    // Baud rates held as 2x integers so that 134.5 baud stays exact.
    function automatic int unsigned baud_x2(input logic [3:0] sel);
        case (sel)
            4'd0:    return 100;
            4'd1:    return 150;
            4'd2:    return 220;
            4'd3:    return 269;
            4'd4:    return 300;
            4'd5:    return 600;
            4'd6:    return 1200;
            4'd7:    return 2400;
            4'd8:    return 3600;
            4'd9:    return 4000;
            4'd10:   return 4800;
            4'd11:   return 7200;
            4'd12:   return 9600;
            4'd13:   return 14400;
            4'd14:   return 19200;
            default: return 38400;
        endcase
    endfunction

    function automatic int unsigned div_calc(input logic [3:0] sel);
        int unsigned b2;
        b2 = baud_x2(sel);
        return (CLK_HZ / 8 + b2 / 2) / b2;
    endfunction

    logic [15:0] div_tab [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_div
        localparam int unsigned DIV_VAL = div_calc(4'(gi));
        if (DIV_VAL < 2 || DIV_VAL > 65535) begin : g_bad_div
            $error("io_uart_baud_gen: divisor for selection %0d out of range", gi);
        end
        assign div_tab[gi] = DIV_VAL[15:0];
    end

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("io_uart_baud_gen: STABLE_CYCLES must be at least 2");
    end

    logic [15:0]       cnt_q,   cnt_d;
    logic              xtr_q,   xtr_d;
    logic              tick_q,  tick_d;
    logic              rchg_q,  rchg_d;
    logic [3:0]        sel_q,   sel_d;
    logic [3:0]        sync1_q, sync2_q;
    logic [STAB_W-1:0] stab_q,  stab_d;
    logic [3:0]        cand_q,  cand_d;

    logic [15:0] div_cur;
    logic [15:0] div_next;
    logic [16:0] div_next_p1;
    logic        wrap;
    logic        apply;
    logic        sync_restart;

    // Divider: a rate change lands either on a wrap or, while held, at once.
    always_comb begin
        div_cur     = div_tab[sel_q];
        wrap        = ENABLE && (cnt_q == div_cur - 16'd1);
        apply       = (cand_q != sel_q) && (wrap || !ENABLE);
        sel_d       = apply ? cand_q : sel_q;
        div_next    = div_tab[sel_d];
        div_next_p1 = {1'b0, div_next} + 17'd1;

        if (apply) begin
            cnt_d = 16'd0;
        end else if (ENABLE) begin
            cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (ENABLE) begin
            xtr_d = (cnt_d < div_next_p1[16:1]);
        end else if (apply) begin
            xtr_d = 1'b1;
        end else begin
            xtr_d = xtr_q;
        end

        tick_d = ENABLE && (cnt_d == 16'd0);
        rchg_d = apply;
    end

    // A pending change of the synchroniser output restarts the stability count
    // on the same edge that the new value reaches sync2_q.
    always_comb begin
        sync_restart = (sync1_q != sync2_q);
        if (sync_restart) begin
            stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 1'b1;
        end
        cand_d = (!sync_restart && stab_d == STAB_MAX) ? sync2_q : cand_q;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q   <= 16'd0;
            xtr_q   <= 1'b1;
            tick_q  <= 1'b0;
            rchg_q  <= 1'b0;
            sel_q   <= RESET_SEL;
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            stab_q  <= '0;
            cand_q  <= RESET_SEL;
        end else begin
            cnt_q   <= cnt_d;
            xtr_q   <= xtr_d;
            tick_q  <= tick_d;
            rchg_q  <= rchg_d;
            sel_q   <= sel_d;
            sync1_q <= BAUD_RATE_SWITCH;
            sync2_q <= sync1_q;
            stab_q  <= stab_d;
            cand_q  <= cand_d;
        end
    end

    assign XTR      = xtr_q;
    assign XTR_TICK = tick_q;
    assign BAUD_SEL = sel_q;
    assign RATE_CHG = rchg_q;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_io_uart_baud_gen
//  Description : Self-checking bench for io_uart_baud_gen against a
//                period-level reference model of the baud table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_baud_gen;

    localparam int unsigned CLK_HZ = 39_321_600;
    localparam int unsigned STABLE = 1024;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       ENABLE;
    logic [3:0] SW;
    logic       XTR;
    logic       XTR_TICK;
    logic [3:0] BAUD_SEL;
    logic       RATE_CHG;

    int checks   = 0;
    int failures = 0;
    int model_sel;

    always #5 CLK = ~CLK;

    io_uart_baud_gen #(
        .CLK_HZ        (CLK_HZ),
        .STABLE_CYCLES (STABLE),
        .RESET_SEL     (4'd14)
    ) dut (
        .CLK              (CLK),
        .RESET_n          (RESET_n),
        .ENABLE           (ENABLE),
        .BAUD_RATE_SWITCH (SW),
        .XTR              (XTR),
        .XTR_TICK         (XTR_TICK),
        .BAUD_SEL         (BAUD_SEL),
        .RATE_CHG         (RATE_CHG)
    );

    // Reference: nearest integer to (CLK_HZ/16)/baud, from the baud rate itself.
    function automatic int ref_div(input int sel);
        real b;
        case (sel)
            0:  b = 50.0;    1:  b = 75.0;    2:  b = 110.0;   3:  b = 134.5;
            4:  b = 150.0;   5:  b = 300.0;   6:  b = 600.0;   7:  b = 1200.0;
            8:  b = 1800.0;  9:  b = 2000.0;  10: b = 2400.0;  11: b = 3600.0;
            12: b = 4800.0;  13: b = 7200.0;  14: b = 9600.0;  default: b = 19200.0;
        endcase
        return $rtoi(real'(CLK_HZ) / 16.0 / b + 0.5);
    endfunction

    // Edges from a switch change (made at count c) to the first wrap that
    // falls no earlier than sync + debounce latency.
    function automatic int ref_apply(input int c, input int div);
        int k;
        k = div - c;
        while (k < int'(STABLE) + 2) k += div;
        return k;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic to_tick(input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (XTR_TICK !== 1'b1 && n < budget);
        if (XTR_TICK !== 1'b1) check({tag, "_tick_timeout"}, 0, 1);
    endtask

    // Called on a tick cycle; returns at the next tick cycle.
    task automatic period(output int hi, output int lo, output int rc);
        hi = 1; lo = 0; rc = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge CLK);
            if (XTR_TICK === 1'b1) break;
            if (XTR === 1'b1) hi++; else lo++;
            if (RATE_CHG === 1'b1) rc++;
        end
        if (XTR_TICK !== 1'b1) check("period_timeout", 0, 1);
    endtask

    task automatic check_periods(input string tag, input int nper);
        int hi, lo, rc, d;
        d = ref_div(model_sel);
        for (int p = 0; p < nper; p++) begin
            period(hi, lo, rc);
            check($sformatf("%s_high_p%0d", tag, p), hi, d - d / 2);
            check($sformatf("%s_low_p%0d", tag, p), lo, d / 2);
            check($sformatf("%s_ratechg_p%0d", tag, p), rc, 0);
        end
    endtask

    // Called on a tick cycle; returns on the RATE_CHG cycle.
    task automatic apply_sel(input int new_sel, input int c);
        int n, last_tick, div_old;
        div_old = ref_div(model_sel);
        cycles(c);
        SW = 4'(new_sel);
        n = 0;
        last_tick = 0;
        while (n < 8000) begin
            @(negedge CLK);
            n++;
            if (RATE_CHG === 1'b1) break;
            if (XTR_TICK === 1'b1) last_tick = n;
        end
        check($sformatf("apply_latency_sel%0d_c%0d", new_sel, c), n, ref_apply(c, div_old));
        check($sformatf("apply_tick_sel%0d", new_sel), int'(XTR_TICK), 1);
        check($sformatf("apply_baudsel_sel%0d", new_sel), int'(BAUD_SEL), new_sel);
        if (last_tick > 0)
            check($sformatf("last_old_period_sel%0d", new_sel), n - last_tick, div_old);
        model_sel = new_sel;
    endtask

    initial begin
        int n, rc, tk, chg, ns, c, x0;

        // Reset state
        RESET_n = 1'b0; ENABLE = 1'b1; SW = 4'd14; model_sel = 14;
        cycles(3);
        check("reset_xtr", int'(XTR), 1);
        check("reset_tick", int'(XTR_TICK), 0);
        check("reset_ratechg", int'(RATE_CHG), 0);
        check("reset_baudsel", int'(BAUD_SEL), 14);
        RESET_n = 1'b1;
        to_tick("first", 2000, n);
        check("first_tick_after_reset", n, ref_div(14));

        // 9600 baud steady state
        check_periods("sel14", 3);
        check("sel14_baudsel", int'(BAUD_SEL), 14);

        // 14 -> 15 at cnt 40, then back to 14
        apply_sel(15, 40);
        check_periods("sel15", 3);
        apply_sel(14, 0);

        // Switch glitches shorter than the debounce window
        SW = 4'd3;  cycles(500);  SW = 4'd14;
        rc = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge CLK);
            if (RATE_CHG === 1'b1) rc++;
        end
        check("glitch500_ratechg", rc, 0);
        check("glitch500_baudsel", int'(BAUD_SEL), 14);
        SW = 4'd3;  cycles(STABLE - 1);  SW = 4'd14;
        rc = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge CLK);
            if (RATE_CHG === 1'b1) rc++;
        end
        check("glitch1023_ratechg", rc, 0);
        check("glitch1023_baudsel", int'(BAUD_SEL), 14);
        to_tick("post_glitch", 600, n);

        // Odd divisor 1365
        apply_sel(8, 17);
        check_periods("sel8", 10);
        apply_sel(14, 300);

        // Hold mid-period with ENABLE low
        cycles(100);
        ENABLE = 1'b0;
        x0 = int'(XTR);
        check("hold_xtr_level", x0, (100 < ref_div(14) - ref_div(14) / 2) ? 1 : 0);
        chg = 0; tk = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (int'(XTR) != x0) chg++;
            if (XTR_TICK === 1'b1) tk++;
        end
        check("hold_xtr_changes", chg, 0);
        check("hold_ticks", tk, 0);
        ENABLE = 1'b1;
        to_tick("resume", 2000, n);
        check("resume_remaining", n, ref_div(14) - 100);

        // Rate change while held is applied immediately and restarts the count
        cycles(50);
        ENABLE = 1'b0;
        SW = 4'd15;
        rc = 0; tk = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK);
            if (RATE_CHG === 1'b1) rc++;
            if (XTR_TICK === 1'b1) tk++;
        end
        check("held_apply_pulses", rc, 1);
        check("held_apply_ticks", tk, 0);
        check("held_apply_baudsel", int'(BAUD_SEL), 15);
        model_sel = 15;
        ENABLE = 1'b1;
        to_tick("held_resume", 2000, n);
        check("held_resume_first_tick", n, ref_div(15));

        // Asynchronous reset mid-period
        cycles(100);
        check("prereset_xtr_low", int'(XTR), 0);
        SW = 4'd14;
        #2 RESET_n = 1'b0;
        #1;
        check("async_reset_xtr", int'(XTR), 1);
        check("async_reset_baudsel", int'(BAUD_SEL), 14);
        check("async_reset_ratechg", int'(RATE_CHG), 0);
        model_sel = 14;
        cycles(3);
        RESET_n = 1'b1;
        to_tick("post_reset", 2000, n);
        check("post_reset_first_tick", n, ref_div(14));
        check_periods("post_reset", 1);

        // Randomised rate changes at random phases
        for (int it = 0; it < 5; it++) begin
            ns = $urandom_range(10, 15);
            if (ns == model_sel) ns = (ns == 15) ? 10 : ns + 1;
            c = $urandom_range(0, ref_div(model_sel) - 1);
            apply_sel(ns, c);
            check_periods($sformatf("rand%0d", it), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
